// File: rtl/range_tracker.sv
// rtl/range_tracker.sv - captures min/max/range of a go..finish sample window.
// Define RANGE_TRACKER_COUNT_EN to build the saturating sample counter.
module range_tracker #(
   parameter int WIDTH  = 8,
   parameter int SIGNED = 0,
   parameter int CNT_W  = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic             go,
   input  logic             finish,
   output logic [WIDTH-1:0] range,
   output logic [WIDTH-1:0] min_val,
   output logic [WIDTH-1:0] max_val,
   output logic [CNT_W-1:0] sample_count,
   output logic             valid,
   output logic             busy,
   output logic             error
);

   typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] run_min_q, run_min_d;
   logic [WIDTH-1:0] run_max_q, run_max_d;
   logic [WIDTH-1:0] min_q, min_d;
   logic [WIDTH-1:0] max_q, max_d;
   logic [WIDTH-1:0] range_q, range_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   logic             error_q, error_d;

   logic             load_first;
   logic             publish;
   logic             clear_res;
   logic [WIDTH-1:0] samp_min;
   logic [WIDTH-1:0] samp_max;
   logic [WIDTH:0]   diff;

   function automatic logic less_than(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      if (SIGNED != 0) return $signed(a) < $signed(b);
      else             return a < b;
   endfunction

   // One extra bit keeps max-min exact for both encodings before truncation.
   function automatic logic [WIDTH:0] extend(input logic [WIDTH-1:0] a);
      return {((SIGNED != 0) & a[WIDTH-1]), a};
   endfunction

   assign samp_min = less_than(data_in, run_min_q) ? data_in : run_min_q;
   assign samp_max = less_than(run_max_q, data_in) ? data_in : run_max_q;
   assign diff     = extend(samp_max) - extend(samp_min);

   always_comb begin
      state_d    = state_q;
      run_min_d  = run_min_q;
      run_max_d  = run_max_q;
      min_d      = min_q;
      max_d      = max_q;
      range_d    = range_q;
      valid_d    = valid_q;
      busy_d     = busy_q;
      error_d    = error_q;
      load_first = 1'b0;
      publish    = 1'b0;
      clear_res  = 1'b0;
      case (state_q)
         RUN: begin
            if (go) begin
               state_d   = ERR;
               min_d     = '0;
               max_d     = '0;
               range_d   = '0;
               clear_res = 1'b1;
               valid_d   = 1'b0;
               busy_d    = 1'b0;
               error_d   = 1'b1;
            end else begin
               run_min_d = samp_min;
               run_max_d = samp_max;
               if (finish) begin
                  state_d = DONE;
                  min_d   = samp_min;
                  max_d   = samp_max;
                  range_d = diff[WIDTH-1:0];
                  publish = 1'b1;
                  valid_d = 1'b1;
                  busy_d  = 1'b0;
               end
            end
         end
         default: begin
            // IDLE, DONE and ERR share the same start/abort decode.
            if (go && !finish) begin
               state_d    = RUN;
               run_min_d  = data_in;
               run_max_d  = data_in;
               load_first = 1'b1;
               valid_d    = 1'b0;
               busy_d     = 1'b1;
               error_d    = 1'b0;
            end else if (finish) begin
               state_d   = ERR;
               min_d     = '0;
               max_d     = '0;
               range_d   = '0;
               clear_res = 1'b1;
               valid_d   = 1'b0;
               busy_d    = 1'b0;
               error_d   = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         run_min_q <= '0;
         run_max_q <= '0;
         min_q     <= '0;
         max_q     <= '0;
         range_q   <= '0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         run_min_q <= run_min_d;
         run_max_q <= run_max_d;
         min_q     <= min_d;
         max_q     <= max_d;
         range_q   <= range_d;
         valid_q   <= valid_d;
         busy_q    <= busy_d;
         error_q   <= error_d;
      end
   end

`ifdef RANGE_TRACKER_COUNT_EN
   logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] cnt_inc;

   // Counts this cycle's sample on top of the running total, pinned at all-ones.
   assign cnt_inc = (&run_cnt_q) ? run_cnt_q : run_cnt_q + CNT_W'(1);

   always_comb begin
      run_cnt_d = run_cnt_q;
      count_d   = count_q;
      if (load_first)            run_cnt_d = CNT_W'(1);
      else if (state_q == RUN)   run_cnt_d = cnt_inc;
      if (publish)               count_d = cnt_inc;
      else if (clear_res)        count_d = '0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         run_cnt_q <= '0;
         count_q   <= '0;
      end else begin
         run_cnt_q <= run_cnt_d;
         count_q   <= count_d;
      end
   end

   assign sample_count = count_q;
`else
   assign sample_count = '0;
`endif

   assign range   = range_q;
   assign min_val = min_q;
   assign max_val = max_q;
   assign valid   = valid_q;
   assign busy    = busy_q;
   assign error   = error_q;

endmodule
